// File: rtl/step_pulse_mc.sv
// -----------------------------------------------------------------------------
// step_pulse_mc
//   Multi-channel stepper step-pulse generator with trapezoidal period ramping.
//   Each channel ramps its running step period toward a latched target by at
//   most RAMP cycles per step, decelerates to N_START before reversing or
//   halting, and keeps a signed step-position count.
//
// Ports
//   clk       system clock (50 MHz)
//   rst       asynchronous, active-low reset
//   d_v       target load strobe, samples N and dir for all channels
//   en        per-channel run enable
//   dir       per-channel requested direction, 1 = forward
//   N         per-channel target period, channel i at [i*PW +: PW]
//   drv_step  per-channel step pulse, PULSE_W cycles high at period start
//   drv_dir   per-channel applied direction
//   busy      per-channel "not idle"
//   n_cur     per-channel period currently applied, 0 when idle
//   pos       per-channel signed position, channel i at [i*POS_W +: POS_W]
// -----------------------------------------------------------------------------
module step_pulse_mc #(
  parameter int NCH     = 2,
  parameter int PW      = 17,
  parameter int PULSE_W = 8,
  parameter int RAMP    = 64,
  parameter int N_START = 4000,
  parameter int POS_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_v,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       dir,
  input  logic [NCH*PW-1:0]    N,
  output logic [NCH-1:0]       drv_step,
  output logic [NCH-1:0]       drv_dir,
  output logic [NCH-1:0]       busy,
  output logic [NCH*PW-1:0]    n_cur,
  output logic [NCH*POS_W-1:0] pos
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REV, ST_STOP} state_t;

  localparam logic [PW-1:0] N_START_P = PW'(N_START);
  localparam logic [PW-1:0] N_MIN_P   = PW'(2 * PULSE_W);
  localparam logic [PW-1:0] RAMP_P    = PW'(RAMP);
  localparam logic [PW-1:0] PULSE_P   = PW'(PULSE_W);

  // Zero stays zero (stop request); everything else is forced into the
  // legal period range.
  function automatic logic [PW-1:0] clamp_tgt(input logic [PW-1:0] n);
    if (n == '0)             return '0;
    else if (n < N_MIN_P)    return N_MIN_P;
    else if (n > N_START_P)  return N_START_P;
    else                     return n;
  endfunction

  // One ramp step toward goal; never overshoots.
  function automatic logic [PW-1:0] ramp_toward(input logic [PW-1:0] cur,
                                                input logic [PW-1:0] goal);
    if (cur > goal)      return (cur - goal > RAMP_P) ? cur - RAMP_P : goal;
    else if (cur < goal) return (goal - cur > RAMP_P) ? cur + RAMP_P : goal;
    else                 return cur;
  endfunction

  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p,
                                                input logic fwd);
    return fwd ? p + POS_W'(1) : p - POS_W'(1);
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t            state_q, state_nxt, eff;
    logic [PW-1:0]     tgt_q, n_q, n_nxt, cnt_q, cnt_nxt;
    logic              dir_req_q, dir_q, dir_nxt, step_q, step_nxt, busy_q;
    logic [POS_W-1:0]  pos_q, pos_nxt;
    logic              stop_c, rev_c, bnd, at_start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tgt_q     <= '0;
        dir_req_q <= 1'b0;
      end else if (d_v) begin
        tgt_q     <= clamp_tgt(N[i*PW +: PW]);
        dir_req_q <= dir[i];
      end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_nxt;
    end

    // Next state. 'eff' is the mode that governs this cycle after applying
    // the stop > reverse precedence; boundary actions act on it.
    always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      stop_c   = !en[i] || (tgt_q == '0);
      rev_c    = (dir_req_q != dir_q);
      bnd      = (state_q != ST_IDLE) && (cnt_q == n_q - PW'(1));
      at_start = (n_q == N_START_P);
      eff      = state_q;
      unique case (state_q)
        ST_IDLE: eff = ST_IDLE;
        ST_RUN:  if (stop_c) eff = ST_STOP; else if (rev_c) eff = ST_REV;
        ST_REV:  if (stop_c) eff = ST_STOP;
        ST_STOP: if (!stop_c) eff = ST_RUN;
        default: eff = ST_IDLE;
      endcase
      state_nxt = eff;
      if (state_q == ST_IDLE) begin
        if (!stop_c) state_nxt = ST_RUN;
      end else if (bnd && at_start) begin
        if (eff == ST_REV)       state_nxt = ST_RUN;
        else if (eff == ST_STOP) state_nxt = ST_IDLE;
      end
    end

    // Output / datapath next values
    always_comb begin
      n_nxt    = n_q;
      cnt_nxt  = cnt_q;
      dir_nxt  = dir_q;
      pos_nxt  = pos_q;
      step_nxt = 1'b0;
      if (state_q == ST_IDLE) begin
        if (state_nxt == ST_RUN) begin
          n_nxt    = N_START_P;
          cnt_nxt  = '0;
          dir_nxt  = dir_req_q;
          step_nxt = 1'b1;
          pos_nxt  = pos_step(pos_q, dir_req_q);
        end
      end else if (bnd) begin
        cnt_nxt = '0;
        if (state_nxt == ST_IDLE) begin
          n_nxt = '0;
        end else begin
          // Reversal point: flip direction and repeat one N_START period.
          if (eff == ST_REV && at_start) dir_nxt = dir_req_q;
          else n_nxt = ramp_toward(n_q, (eff == ST_RUN) ? tgt_q : N_START_P);
          step_nxt = 1'b1;
          pos_nxt  = pos_step(pos_q, dir_nxt);
        end
      end else begin
        cnt_nxt  = cnt_q + PW'(1);
        step_nxt = (cnt_nxt < PULSE_P);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        n_q    <= '0;
        cnt_q  <= '0;
        dir_q  <= 1'b0;
        step_q <= 1'b0;
        busy_q <= 1'b0;
        pos_q  <= '0;
      end else begin
        n_q    <= n_nxt;
        cnt_q  <= cnt_nxt;
        dir_q  <= dir_nxt;
        step_q <= step_nxt;
        busy_q <= (state_nxt != ST_IDLE);
        pos_q  <= pos_nxt;
      end
    end

    assign drv_step[i]              = step_q;
    assign drv_dir[i]               = dir_q;
    assign busy[i]                  = busy_q;
    assign n_cur[i*PW +: PW]        = n_q;
    assign pos[i*POS_W +: POS_W]    = pos_q;
  end

endmodule

// File: tb/tb_step_pulse_mc.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_mc
//   Directed scenarios with randomized timing, directions and don't-care
//   inputs. A monitor logs every step rise (cycle, pos, drv_dir) and every
//   pulse width; expected period sequences are built from the ramp rules.
// -----------------------------------------------------------------------------
module tb_step_pulse_mc;

  localparam int NCH = 2, PW = 17, PULSE_W = 4, RAMP = 100, N_START = 1000, POS_W = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 d_v;
  logic [NCH-1:0]       en, dir;
  logic [NCH*PW-1:0]    N;
  logic [NCH-1:0]       drv_step, drv_dir, busy;
  logic [NCH*PW-1:0]    n_cur;
  logic [NCH*POS_W-1:0] pos;

  step_pulse_mc #(.NCH(NCH), .PW(PW), .PULSE_W(PULSE_W), .RAMP(RAMP),
                  .N_START(N_START), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .d_v(d_v), .en(en), .dir(dir), .N(N),
    .drv_step(drv_step), .drv_dir(drv_dir), .busy(busy), .n_cur(n_cur), .pos(pos)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  bit              mon_on = 1'b1;
  logic [NCH-1:0]  step_prev = '0;
  int              hi_len [NCH];
  int              rise_q [NCH][$];
  logic [31:0]     rpos_q [NCH][$];
  bit              rdir_q [NCH][$];
  int              wid_q  [NCH][$];

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (mon_on) begin
        if (drv_step[c] && !step_prev[c]) begin
          rise_q[c].push_back(cyc);
          rpos_q[c].push_back(pos[c*POS_W +: POS_W]);
          rdir_q[c].push_back(drv_dir[c]);
          hi_len[c] <= 1;
        end else if (drv_step[c]) begin
          hi_len[c] <= hi_len[c] + 1;
        end else if (step_prev[c]) begin
          wid_q[c].push_back(hi_len[c]);
        end
      end
      step_prev[c] <= drv_step[c];
    end
  end

  // Reference state
  int          n_total = 0, n_pass = 0;
  int          exp_per[$];
  bit          exp_dir[$];
  logic [31:0] model_pos [NCH] = '{default: '0};
  int          last_idx  [NCH] = '{default: -1};
  int          wchk      [NCH] = '{default: 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
  endtask

  task automatic push_const(input int v, input int cnt, input bit d);
    repeat (cnt) begin exp_per.push_back(v); exp_dir.push_back(d); end
  endtask

  // Period sequence from 'from' to 'goal' (inclusive), moving at most RAMP per step.
  task automatic push_ramp(input int from, input int goal, input bit d);
    int v = from;
    push_const(v, 1, d);
    while (v != goal) begin
      if (v > goal) v = (v - RAMP > goal) ? v - RAMP : goal;
      else          v = (v + RAMP < goal) ? v + RAMP : goal;
      push_const(v, 1, d);
    end
  endtask

  task automatic load(input int n0, input bit d0, input int n1, input bit d1);
    @(negedge clk);
    N = {PW'(n1), PW'(n0)}; dir = {d1, d0}; d_v = 1'b1;
    @(negedge clk);
    d_v = 1'b0; N = {PW'($urandom), PW'($urandom)}; dir = NCH'($urandom);
  endtask

  task automatic wait_rise(input int c, output int idx);
    int w = 0;
    idx = last_idx[c] + 1;
    while (rise_q[c].size() <= idx && w < 2000) begin @(negedge clk); w++; end
    check($sformatf("ch%0d rise wait", c), 64'(rise_q[c].size() > idx), 64'd1);
  endtask

  // Checks spacings between rises base..base+n (n = exp_per.size()), plus
  // direction and position at each of those rises, plus new pulse widths.
  task automatic verify(input int c, input int base, input bit last_dir, input string tag);
    int n = exp_per.size();
    int budget = 3000;
    int w = 0;
    bit d;
    foreach (exp_per[k]) budget += exp_per[k];
    while (rise_q[c].size() < base + n + 1 && w < budget) begin @(negedge clk); w++; end
    check($sformatf("%s ch%0d rise count", tag, c), 64'(rise_q[c].size() >= base + n + 1), 64'd1);
    if (rise_q[c].size() >= base + n + 1) begin
      for (int k = 0; k <= n; k++) begin
        d = (k < n) ? exp_dir[k] : last_dir;
        if (k < n)
          check($sformatf("%s ch%0d spacing %0d", tag, c, k),
                64'(rise_q[c][base+k+1] - rise_q[c][base+k]), 64'(exp_per[k]));
        check($sformatf("%s ch%0d dir %0d", tag, c, k), 64'(rdir_q[c][base+k]), 64'(d));
        if (base + k > last_idx[c]) begin
          model_pos[c] = d ? model_pos[c] + 32'd1 : model_pos[c] - 32'd1;
          last_idx[c]  = base + k;
        end
        check($sformatf("%s ch%0d pos %0d", tag, c, k), 64'(rpos_q[c][base+k]), 64'(model_pos[c]));
      end
    end
    while (wchk[c] < wid_q[c].size()) begin
      check($sformatf("%s ch%0d pulse width %0d", tag, c, wchk[c]), 64'(wid_q[c][wchk[c]]), 64'(PULSE_W));
      wchk[c]++;
    end
    exp_per.delete();
    exp_dir.delete();
  endtask

  // Rise r starts the final N_START period; the channel must go idle right after it.
  task automatic check_idle(input int c, input int r, input string tag);
    while (cyc < r + N_START - 1) @(negedge clk);
    check({tag, " busy before end"}, 64'(busy[c]), 64'd1);
    check({tag, " n_cur before end"}, 64'(n_cur[c*PW +: PW]), 64'(N_START));
    while (cyc < r + N_START) @(negedge clk);
    check({tag, " busy after end"}, 64'(busy[c]), 64'd0);
    check({tag, " n_cur after end"}, 64'(n_cur[c*PW +: PW]), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " drv_step"}, 64'(drv_step), 64'd0);
    check({tag, " drv_dir"},  64'(drv_dir),  64'd0);
    check({tag, " busy"},     64'(busy),     64'd0);
    check({tag, " n_cur"},    64'(n_cur),    64'd0);
    check({tag, " pos"},      64'(pos),      64'd0);
  endtask

  initial begin
    int j, base0, base1;
    bit da, db;

    // Reset with random inputs
    rst = 1'b0; d_v = 1'b0; en = '0; dir = '0; N = '0;
    repeat (5) begin
      @(negedge clk);
      d_v = 1'($urandom); en = NCH'($urandom); dir = NCH'($urandom);
      N = {PW'($urandom), PW'($urandom)};
    end
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1; en = '0;
    repeat (10) begin
      @(negedge clk);
      d_v = 1'($urandom); dir = NCH'($urandom); N = {PW'($urandom), PW'($urandom)};
    end
    d_v = 1'b0;
    @(negedge clk);
    check_all_zero("idle after reset");

    // Accelerate ch0 to 500, forward
    load(500, 1'b1, 0, 1'b0);
    en = 2'b01;
    push_ramp(1000, 500, 1'b1);
    push_const(500, 2, 1'b1);
    verify(0, 0, 1'b1, "accel");
    check("accel ch1 busy", 64'(busy[1]), 64'd0);
    check("accel ch1 n_cur", 64'(n_cur[PW +: PW]), 64'd0);
    check("accel ch1 rises", 64'(rise_q[1].size()), 64'd0);

    // Reverse at 500 cruise
    wait_rise(0, j);
    repeat (5 + $urandom_range(0, 100)) @(negedge clk);
    load(500, 1'b0, 0, 1'b0);
    push_const(500, 1, 1'b1);
    push_ramp(600, 1000, 1'b1);
    push_ramp(1000, 500, 1'b0);
    push_const(500, 1, 1'b0);
    verify(0, j, 1'b0, "reverse");

    // Stop from 500 cruise
    wait_rise(0, j);
    repeat (5 + $urandom_range(0, 100)) @(negedge clk);
    en[0] = 1'b0;
    push_ramp(500, 900, 1'b0);
    verify(0, j, 1'b0, "stop");
    check_idle(0, rise_q[0][last_idx[0]], "stop");
    repeat (100) @(negedge clk);
    check("stop pos frozen", 64'(pos[0 +: POS_W]), 64'(model_pos[0]));
    check("stop no extra rise", 64'(rise_q[0].size()), 64'(last_idx[0] + 1));

    // Clamp low: N0=3 -> period 8
    da = 1'($urandom);
    load(3, da, 0, 1'b0);
    en[0] = 1'b1;
    base0 = last_idx[0] + 1;
    push_ramp(1000, 8, da);
    push_const(8, 3, da);
    verify(0, base0, da, "clamp low");

    // N0=0 is a stop request
    wait_rise(0, j);
    load(0, da, 0, 1'b0);
    push_const(8, 1, da);
    push_ramp(108, 908, da);
    verify(0, j, da, "stop request");
    check_idle(0, rise_q[0][last_idx[0]], "stop request");

    // Clamp high: N0=70000 -> period 1000 (en0 still high)
    db = 1'($urandom);
    load(70000, db, 0, 1'b0);
    base0 = last_idx[0] + 1;
    push_const(1000, 3, db);
    verify(0, base0, db, "clamp high");
    en[0] = 1'b0;
    check_idle(0, rise_q[0][last_idx[0]], "clamp high halt");

    // Independent channels at 500 and 800
    da = 1'($urandom);
    db = 1'($urandom);
    load(500, da, 800, db);
    en = 2'b11;
    base0 = last_idx[0] + 1;
    base1 = last_idx[1] + 1;
    push_ramp(1000, 500, da);
    push_const(500, 2, da);
    verify(0, base0, da, "indep");
    push_ramp(1000, 800, db);
    push_const(800, 3, db);
    verify(1, base1, db, "indep");
    check("indep common start", 64'(rise_q[0][base0]), 64'(rise_q[1][base1]));

    // Asynchronous reset in the middle of a ch0 pulse
    wait_rise(0, j);
    check("pre-reset drv_step0", 64'(drv_step[0]), 64'd1);
    mon_on = 1'b0;
    #1 rst = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    rst = 1'b1; en = '0;
    repeat (20) @(negedge clk);
    check_all_zero("after async reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
